decoder_scan_n: RTL and testbench
=================================

// Module: decoder_scan_n
// PURPOSE
//   Parametrised, registered one-hot decoder; next generation of the 3-to-8 decoder.
//   DIRECT mode: registered one-hot decode of a select input.
//   SCAN mode: walks the active output across all OUT_W lines, holding each for a
//   programmable dwell time.
//   Drives row/digit strobes for multiplexed LED/display logic. Emits one wrap pulse
//   per completed sweep.
// PARAMETERS
//   SEL_W    3            select width
//   OUT_W    2**SEL_W     output lines; legal range 2..2**SEL_W
//   DWELL_W  8            dwell-count width; each line is held for dwell+1 cycles
// PORTS
//   clk      in   1        single clock, rising edge
//   rst_n    in   1        asynchronous reset, active low
//   a        in   SEL_W    DIRECT: line to assert; SCAN: start line sampled on entry or load
//   enable   in   1        0 forces outputs off and the FSM to IDLE
//   mode     in   1        0 = DIRECT, 1 = SCAN
//   dwell    in   DWELL_W  SCAN hold length minus 1; sampled at each step start
//   load     in   1        SCAN restart strobe: jump to line a, clear dwell counter
//   y        out  OUT_W    registered one-hot output, or all zero
//   idx      out  SEL_W    index of the active line, registered
//   wrap     out  1        1-cycle pulse on the step OUT_W-1 -> 0 in SCAN
// BEHAVIOUR
//   Reset (async assert, sync release)
//     y=0, idx=0, wrap=0, dwell counter=0, state=IDLE.
//   FSM states: IDLE, DIRECT, SCAN.
//     Transitions are evaluated every clk; the priority order is the one listed below.
//   1. enable=0: next cycle state=IDLE, y=0, idx=0, wrap=0, counter=0.
//      Overrides mode, load and dwell.
//   2. enable=1, mode=0: state=DIRECT.
//      - y <= onehot(a), idx <= a; latency 1 clk.
//      - a >= OUT_W: y <= 0, idx <= a.
//   3. enable=1, mode=1, entering from IDLE or DIRECT: state=SCAN.
//      - idx <= a (a >= OUT_W is treated as 0); y <= onehot(idx).
//      - Dwell counter loads dwell.
//   4. In SCAN:
//      - Counter decrements each clk.
//      - At counter==0: idx <= (idx==OUT_W-1) ? 0 : idx+1, counter reloads the current
//        dwell, y follows idx in the same edge.
//      - wrap=1 for exactly the cycle in which y first shows line 0 after line OUT_W-1.
//   5. load=1 in SCAN: behaves like entry (3), no wrap pulse.
//      load wins over a simultaneous dwell expiry. load is ignored in DIRECT and IDLE.
//   Dwell timing: dwell=0 steps every clk; full sweep = OUT_W*(dwell+1) clks.
//   Mode change mid-sweep takes effect on the next edge:
//     - SCAN->DIRECT: y = onehot(a) next cycle; counter cleared.
//     - DIRECT->SCAN: starts at a.
//   Invariant: y is always one-hot or zero, and never has more than one bit set.
//   All outputs are registered; no combinational path from inputs to outputs.
// STRUCTURE
//   Package decoder_pkg holds:
//     - state encodings ST_IDLE, ST_DIRECT, ST_SCAN (2-bit)
//     - MODE_DIRECT=1'b0, MODE_SCAN=1'b1
//     - function onehot_f(sel, out_w) with range check
//   Sub-module onehot_dec #(SEL_W,OUT_W): purely combinational.
//     - Default branch drives all zeros, so no latches.
//     - Instantiated once, on the next-idx value.
//   Top module contains the FSM, dwell counter, idx register and wrap logic.
// TESTING
//   1. Reset mid-run: assert rst_n=0 during a SCAN sweep -> y, idx and wrap all 0
//      immediately, with no clk edge.
//   2. DIRECT, OUT_W=8: a=5 -> y=8'b0010_0000 and idx=5 one clk later.
//      With OUT_W=6 and a=7 -> y=0.
//   3. SCAN, dwell=2, a=6, OUT_W=8 -> lines held 3 clks each, sequence 6,7,0,1.
//      wrap is high only in the first cycle of line 0.
//   4. SCAN, dwell=0 -> idx steps every clk; wrap period is exactly 8 clks.
//   5. SCAN: load=1 with a=3 in the same cycle as dwell expiry -> idx=3,
//      counter reloaded, no wrap.
//   6. enable falls mid-sweep -> y=0 next clk.
//      enable rises with mode=1, a=2 -> scan restarts at line 2.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and helpers for the scanning one-hot decoder family.
package decoder_pkg;

   localparam int unsigned MAX_SEL_W = 8;
   localparam int unsigned MAX_OUT_W = 2**MAX_SEL_W;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DIRECT = 2'd1,
      ST_SCAN   = 2'd2
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   // One-hot of sel across out_w lines; all zero when sel is out of range.
   function automatic logic [MAX_OUT_W-1:0] onehot_f(input logic [MAX_SEL_W-1:0] sel,
                                                     input int unsigned out_w);
      onehot_f = '0;
      if (32'(sel) < out_w) onehot_f[sel] = 1'b1;
   endfunction

endpackage

// File: rtl/decoder_scan_n_onehot_dec.sv
// Combinational range-checked one-hot decoder.
module onehot_dec
   import decoder_pkg::*;
#(
   parameter int unsigned SEL_W = 3,
   parameter int unsigned OUT_W = 2**SEL_W
) (
   input  logic [SEL_W-1:0] a,
   output logic [OUT_W-1:0] y
);

   always_comb begin
      y = '0;
      y = OUT_W'(onehot_f(MAX_SEL_W'(a), OUT_W));
   end

endmodule

// File: rtl/decoder_scan_n.sv
// Registered one-hot decoder with a direct mode and a dwell-timed scan mode
// that walks the active line across all outputs and pulses wrap once per sweep.
module decoder_scan_n
   import decoder_pkg::*;
#(
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned OUT_W   = 2**SEL_W,
   parameter int unsigned DWELL_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [SEL_W-1:0]   a,
   input  logic               enable,
   input  logic               mode,
   input  logic [DWELL_W-1:0] dwell,
   input  logic               load,
   output logic [OUT_W-1:0]   y,
   output logic [SEL_W-1:0]   idx,
   output logic               wrap
);

   localparam int unsigned       CMP_W   = SEL_W + 1;
   localparam logic [CMP_W-1:0]  OUT_W_C = CMP_W'(OUT_W);
   localparam logic [SEL_W-1:0]  LAST    = SEL_W'(OUT_W - 1);

   state_e             state_q, state_d;
   logic [DWELL_W-1:0] cnt_q, cnt_d;
   logic [SEL_W-1:0]   idx_d;
   logic               wrap_d;
   logic [OUT_W-1:0]   y_d;
   logic [OUT_W-1:0]   dec_y;
   logic               a_in_range_c;

   assign a_in_range_c = ({1'b0, a} < OUT_W_C);

   // Next-state: enable beats mode, scan entry/load beats dwell expiry.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx;
      wrap_d  = 1'b0;
      if (!enable) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
      end else if (mode == MODE_DIRECT) begin
         state_d = ST_DIRECT;
         idx_d   = a;
         cnt_d   = '0;
      end else if (state_q != ST_SCAN || load) begin
         state_d = ST_SCAN;
         idx_d   = a_in_range_c ? a : '0;
         cnt_d   = dwell;
      end else if (cnt_q == '0) begin
         cnt_d  = dwell;
         wrap_d = (idx == LAST);
         idx_d  = (idx == LAST) ? '0 : idx + SEL_W'(1);
      end else begin
         cnt_d = cnt_q - DWELL_W'(1);
      end
   end

   onehot_dec #(
      .SEL_W (SEL_W),
      .OUT_W (OUT_W)
   ) u_dec (
      .a (idx_d),
      .y (dec_y)
   );

   // Out-of-range direct selects decode to zero inside onehot_dec.
   assign y_d = enable ? dec_y : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         idx     <= '0;
         y       <= '0;
         wrap    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx     <= idx_d;
         y       <= y_d;
         wrap    <= wrap_d;
      end
   end

endmodule

// File: tb/tb_decoder_scan_n.sv
// Scoreboard bench: two decoder instances (8 and 6 lines) against a sweep-level model.
module tb_decoder_scan_n;

   localparam int unsigned SEL_W   = 3;
   localparam int unsigned DWELL_W = 8;

   logic               clk = 1'b0;
   logic               rst_n;
   logic [SEL_W-1:0]   a;
   logic               enable, mode, load;
   logic [DWELL_W-1:0] dwell;
   logic [7:0]         y8;
   logic [5:0]         y6;
   logic [SEL_W-1:0]   idx8, idx6;
   logic               wrap8, wrap6;

   always #5 clk = ~clk;

   decoder_scan_n #(.SEL_W(SEL_W), .OUT_W(8), .DWELL_W(DWELL_W)) dut8 (
      .clk(clk), .rst_n(rst_n), .a(a), .enable(enable), .mode(mode),
      .dwell(dwell), .load(load), .y(y8), .idx(idx8), .wrap(wrap8));

   decoder_scan_n #(.SEL_W(SEL_W), .OUT_W(6), .DWELL_W(DWELL_W)) dut6 (
      .clk(clk), .rst_n(rst_n), .a(a), .enable(enable), .mode(mode),
      .dwell(dwell), .load(load), .y(y6), .idx(idx6), .wrap(wrap6));

   // Model: phase 0 off, 1 direct, 2 scanning; line and cycles left on it.
   typedef struct {
      int phase; int line; int left; int idx; int y; int wrap;
   } mdl_t;
   typedef struct {
      int y8; int idx8; int w8; int y6; int idx6; int w6;
   } exp_t;

   exp_t q[$];
   mdl_t m8, m6;
   int   checks = 0;
   int   errors = 0;

   function automatic mdl_t mreset();
      mdl_t m;
      m.phase = 0; m.line = 0; m.left = 0; m.idx = 0; m.y = 0; m.wrap = 0;
      return m;
   endfunction

   function automatic mdl_t mstep(input mdl_t mi, input int ow, input int en,
                                  input int md, input int ld, input int aa, input int dw);
      mdl_t m = mi;
      m.wrap = 0;
      if (en == 0) begin
         m = mreset();
      end else if (md == 0) begin
         m.phase = 1; m.left = 0; m.idx = aa;
         m.y = (aa < ow) ? (1 << aa) : 0;
      end else begin
         if (m.phase != 2 || ld != 0) begin
            m.phase = 2;
            m.line  = (aa < ow) ? aa : 0;
            m.left  = dw;
         end else if (m.left == 0) begin
            m.wrap = (m.line == ow - 1) ? 1 : 0;
            m.line = (m.line + 1) % ow;
            m.left = dw;
         end else begin
            m.left = m.left - 1;
         end
         m.idx = m.line;
         m.y   = 1 << m.line;
      end
      return m;
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic drive(input int en, input int md, input int ld, input int aa, input int dw);
      exp_t e;
      @(negedge clk);
      enable = 1'(en); mode = 1'(md); load = 1'(ld);
      a = SEL_W'(aa); dwell = DWELL_W'(dw);
      m8 = mstep(m8, 8, en, md, ld, aa, dw);
      m6 = mstep(m6, 6, en, md, ld, aa, dw);
      e.y8 = m8.y; e.idx8 = m8.idx; e.w8 = m8.wrap;
      e.y6 = m6.y; e.idx6 = m6.idx; e.w6 = m6.wrap;
      q.push_back(e);
   endtask

   // Monitor: every clock edge retires one expected response.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("y8",    32'(y8),    e.y8);
            check("idx8",  32'(idx8),  e.idx8);
            check("wrap8", 32'(wrap8), e.w8);
            check("y6",    32'(y6),    e.y6);
            check("idx6",  32'(idx6),  e.idx6);
            check("wrap6", 32'(wrap6), e.w6);
         end
      end
   end

   initial begin
      int seq_idx [12];
      int w_first, w_last, cyc;
      seq_idx = '{6, 6, 6, 7, 7, 7, 0, 0, 0, 1, 1, 1};

      rst_n = 1'b0; enable = 1'b0; mode = 1'b0; load = 1'b0; a = '0; dwell = '0;
      m8 = mreset(); m6 = mreset();
      repeat (2) @(posedge clk);
      #2;
      check("rst_y8", 32'(y8), 0);
      check("rst_idx8", 32'(idx8), 0);
      check("rst_wrap8", 32'(wrap8), 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Direct decode, including a select beyond the 6-line instance.
      drive(1, 0, 0, 5, 0);
      @(posedge clk); #2;
      check("direct_y8_a5", 32'(y8), 32'h20);
      check("direct_idx8_a5", 32'(idx8), 5);
      drive(1, 0, 0, 7, 0);
      @(posedge clk); #2;
      check("direct_y6_a7", 32'(y6), 0);
      check("direct_idx6_a7", 32'(idx6), 7);

      // Scan from line 6 with dwell 2: three cycles per line, wrap on first cycle of 0.
      drive(1, 0, 0, 1, 0);
      for (int i = 0; i < 12; i++) begin
         drive(1, 1, 0, 6, 2);
         @(posedge clk); #2;
         check("scan_seq_idx8", 32'(idx8), seq_idx[i]);
         check("scan_seq_wrap8", 32'(wrap8), (i == 6) ? 1 : 0);
      end

      // Dwell 0: one step per clock, wrap period equals the line count.
      w_first = -100; w_last = -100; cyc = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 0, 0, 0);
         cyc++;
         @(posedge clk); #2;
         if (wrap8) begin
            w_first = w_last;
            w_last  = cyc;
         end
      end
      check("wrap_period8", 32'(w_last - w_first), 8);

      // Load coinciding with a wrapping dwell expiry: jump to 3, no wrap.
      drive(0, 0, 0, 0, 0);
      drive(1, 1, 0, 7, 1);
      drive(1, 1, 0, 7, 1);
      drive(1, 1, 1, 3, 1);
      @(posedge clk); #2;
      check("load_idx8", 32'(idx8), 3);
      check("load_wrap8", 32'(wrap8), 0);
      drive(1, 1, 0, 0, 1);
      drive(1, 1, 0, 0, 1);
      @(posedge clk); #2;
      check("load_reload_idx8", 32'(idx8), 4);

      // Enable drop and restart at line 2.
      drive(0, 1, 0, 0, 1);
      @(posedge clk); #2;
      check("en_off_y8", 32'(y8), 0);
      drive(1, 1, 0, 2, 1);
      @(posedge clk); #2;
      check("restart_idx8", 32'(idx8), 2);
      check("restart_y8", 32'(y8), 32'h04);

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom_range(0, 15) != 0) ? 1 : 0,
               ($urandom_range(0, 7) != 0) ? 1 : 0,
               ($urandom_range(0, 9) == 0) ? 1 : 0,
               int'($urandom_range(0, 7)),
               int'($urandom_range(0, 3)));
      end

      // Asynchronous reset in the middle of a sweep.
      drive(1, 1, 0, 4, 3);
      drive(1, 1, 0, 4, 3);
      @(posedge clk); #3;
      rst_n = 1'b0; enable = 1'b0;
      #1;
      check("async_rst_y8", 32'(y8), 0);
      check("async_rst_idx8", 32'(idx8), 0);
      check("async_rst_wrap8", 32'(wrap8), 0);
      check("async_rst_y6", 32'(y6), 0);
      m8 = mreset(); m6 = mreset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 1, 0, 5, 0);
      drive(1, 1, 0, 5, 0);

      repeat (3) @(posedge clk);
      #2;
      check("queue_drained", 32'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
